fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default MEM_ADDR_SIZE, meaning the width of the program counter and memory address.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mem_addr_o, output, ADDR_W bits: read address to the memory.
REQ-006 SHALL have port mem_data_i, input, 24 bits: {byte[addr+2], byte[addr+1], byte[addr+0]}, combinationally valid in the same cycle as mem_addr_o.
REQ-007 SHALL have port instr_valid_o, output, 1 bit: the instruction register holds a fetched instruction.
REQ-008 SHALL have port instr_ready_i, input, 1 bit: downstream accepts the instruction this cycle.
REQ-009 SHALL have port instr_opcode_o, output, 8 bits: the opcode byte.
REQ-010 SHALL have port instr_operand_o, output, 16 bits: {byte+2, byte+1}; unused bytes are zeroed per REQ-017.
REQ-011 SHALL have port instr_len_o, output, 2 bits: instruction length, 1..3.
REQ-012 SHALL have port instr_pc_o, output, ADDR_W bits: address of the opcode.
REQ-013 SHALL have port illegal_o, output, 1 bit: the held opcode is illegal (cc=11).
REQ-014 SHALL have port redirect_i, input, 1 bit, and port redirect_pc_i, input, ADDR_W bits: branch/jump target load.

Function
REQ-015 SHALL use FSM states BOOT, RUN, HALT; BOOT always moves to RUN after one cycle, with no fetch captured in BOOT.
REQ-016 SHALL drive mem_addr_o = pc at all times.
REQ-017 SHALL decode length from opcode aaabbbcc, with unused operand bytes zeroed:
- cc=01: bbb in {011,110,111} -> 3; else 2.
- cc=10: bbb in {011,111} -> 3; bbb in {010,110} -> 1; else 2.
- cc=00: bbb in {011,111} -> 3; bbb=000: 0x20 -> 3, 0x00/0x40/0x60 -> 1, else 2; bbb in {010,110} -> 1; else 2.
- cc=11: 1, and flagged illegal.
REQ-018 SHALL perform a load (capture mem_data_i, pc, len and illegal into the output register; set valid=1; pc <= pc+len mod 2^ADDR_W) when state=RUN and (instr_valid_o=0 or instr_ready_i=1).
REQ-019 SHALL, when state=RUN, instr_valid_o=1 and instr_ready_i=0, hold all outputs and pc stable (stall).
REQ-020 SHALL, when state=RUN and instr_ready_i=1 with no load possible, clear valid; this case arises only on a HALT transition.
REQ-021 SHALL, on a load with a cc=11 opcode, move to HALT; in HALT no further loads occur, the held instruction stays until accepted, then valid clears.
REQ-022 SHALL give redirect_i=1 priority over everything in any state: valid <= 0, pc <= redirect_pc_i, state <= RUN; no capture that cycle; first load of the target occurs on the next cycle.
REQ-023 SHALL wrap pc modulo 2^ADDR_W, so pc=max with len=2 gives next pc=1.
REQ-024 SHALL have a latency of one cycle from pc presentation to instr_valid_o; throughput is one instruction per cycle with ready held high.

Reset
REQ-025 SHALL, while rstn_i=0, force state=BOOT, pc=RESET_PC, instr_valid_o=0, illegal_o=0, instr_opcode_o=0, instr_operand_o=0, instr_len_o=0, instr_pc_o=0, with immediate effect.
REQ-026 SHALL abandon an in-flight instruction on reset mid-operation with no output glitch after release; first valid appears at the 2nd rising edge after deassertion.

Verification
REQ-027 SHALL cover: memory filled with 0x05,i+1,i+1 pattern, ready=1 -> pc_o sequence 0,3? no, len=2: 0,2,4..., opcode 0x05, len 2, valid every cycle from the 2nd edge after reset.
REQ-028 SHALL cover: opcodes 0xEA, 0xA9 0x10, 0x4C 0x34 0x12 at 0 -> len 1,2,3; operands 0x0000, 0x0010, 0x1234; pc_o 0,1,3.
REQ-029 SHALL cover: ready=0 for 3 cycles with valid=1 -> all outputs and mem_addr_o constant, then one accept advances pc by len.
REQ-030 SHALL cover: redirect_i with redirect_pc_i=0x0200 while stalled -> valid drops next cycle, mem_addr_o=0x0200, next instr_pc_o=0x0200.
REQ-031 SHALL cover: opcode 0x03 fetched -> illegal_o=1, len 1, no further loads; after accept valid=0 until redirect.
REQ-032 SHALL cover: pc=0xFFFF with 2-byte opcode, or rstn_i pulsed mid-stream -> next pc 0x0001; reset returns all outputs to 0 and pc to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: byte-stream instruction fetcher for an 8-bit opcode ISA with
// 1..3 byte instructions. Presents pc to a combinational 3-byte memory port,
// decodes the instruction length from the opcode, and registers opcode,
// operand, length and pc into a valid/ready output stage. An illegal opcode
// (cc=11) parks the unit in HALT until a redirect.

package fetch_unit_pkg;
    // Width of the program memory address bus.
    localparam int MEM_ADDR_SIZE = 16;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = MEM_ADDR_SIZE,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    // Memory read port: data is combinational on the address.
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [23:0]       mem_data_i,

    // Instruction output stage
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [7:0]        instr_opcode_o,
    output logic [15:0]       instr_operand_o,
    output logic [1:0]        instr_len_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              illegal_o,

    // Branch / jump target load
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [ADDR_W-1:0] pc_reg;
    logic              valid_reg;
    logic [7:0]        opcode_reg;
    logic [15:0]       operand_reg;
    logic [1:0]        len_reg;
    logic [ADDR_W-1:0] ipc_reg;
    logic              illegal_reg;

    // Decode of the bytes currently presented by memory.
    logic [7:0]        dec_opcode;
    logic [2:0]        dec_aaa;
    logic [2:0]        dec_bbb;
    logic [1:0]        dec_cc;
    logic [1:0]        dec_len;
    logic              dec_illegal;
    logic [15:0]       dec_operand;
    logic [ADDR_W-1:0] pc_seq;

    // Control strobes from the FSM.
    logic              load_en;
    logic              drop_valid;
    logic              take_redirect;

    assign dec_opcode = mem_data_i[7:0];
    assign dec_aaa    = dec_opcode[7:5];
    assign dec_bbb    = dec_opcode[4:2];
    assign dec_cc     = dec_opcode[1:0];

    // Length decode from the opcode fields aaa/bbb/cc.
    always_comb begin
        dec_len     = 2'd2;
        dec_illegal = 1'b0;
        case (dec_cc)
            2'b01: begin
                if (dec_bbb == 3'b011 || dec_bbb == 3'b110 || dec_bbb == 3'b111)
                    dec_len = 2'd3;
                else
                    dec_len = 2'd2;
            end
            2'b10: begin
                if (dec_bbb == 3'b011 || dec_bbb == 3'b111)
                    dec_len = 2'd3;
                else if (dec_bbb == 3'b010 || dec_bbb == 3'b110)
                    dec_len = 2'd1;
                else
                    dec_len = 2'd2;
            end
            2'b00: begin
                if (dec_bbb == 3'b011 || dec_bbb == 3'b111) begin
                    dec_len = 2'd3;
                end else if (dec_bbb == 3'b000) begin
                    // Row 000 mixes a 3-byte call (0x20), three single-byte
                    // opcodes (0x00/0x40/0x60) and 2-byte immediates.
                    if (dec_aaa == 3'b001)
                        dec_len = 2'd3;
                    else if (dec_aaa == 3'b000 || dec_aaa == 3'b010 || dec_aaa == 3'b011)
                        dec_len = 2'd1;
                    else
                        dec_len = 2'd2;
                end else if (dec_bbb == 3'b010 || dec_bbb == 3'b110) begin
                    dec_len = 2'd1;
                end else begin
                    dec_len = 2'd2;
                end
            end
            default: begin
                // cc=11 is not a valid opcode group; consume one byte and flag it.
                dec_len     = 2'd1;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Operand byte gi is byte gi+1 of the instruction; it only exists when
    // the instruction is longer than gi+1 bytes, otherwise it reads as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign dec_operand[8*gi +: 8] =
                (dec_len > 2'(gi + 1)) ? mem_data_i[8*(gi+1) +: 8] : 8'h00;
        end
    endgenerate

    // Sequential next pc; wraps naturally at 2^ADDR_W.
    assign pc_seq = pc_reg + ADDR_W'(dec_len);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            state_reg <= BOOT;
        else
            state_reg <= state_next;
    end

    // FSM next state and datapath strobes; redirect overrides every state.
    always_comb begin
        state_next    = state_reg;
        load_en       = 1'b0;
        drop_valid    = 1'b0;
        take_redirect = 1'b0;
        if (redirect_i) begin
            take_redirect = 1'b1;
            state_next    = RUN;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_next = RUN;
                end
                RUN: begin
                    if (!valid_reg || instr_ready_i) begin
                        load_en = 1'b1;
                        if (dec_illegal)
                            state_next = HALT;
                    end
                end
                HALT: begin
                    // Let the illegal instruction drain, then stay empty.
                    if (valid_reg && instr_ready_i)
                        drop_valid = 1'b1;
                end
                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    // Program counter: redirect target, or advance past each loaded instruction.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            pc_reg <= RESET_PC;
        else if (take_redirect)
            pc_reg <= redirect_pc_i;
        else if (load_en)
            pc_reg <= pc_seq;
    end

    // Output valid flag: set on load, cleared on redirect or a HALT drain.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            valid_reg <= 1'b0;
        else if (take_redirect)
            valid_reg <= 1'b0;
        else if (load_en)
            valid_reg <= 1'b1;
        else if (drop_valid)
            valid_reg <= 1'b0;
    end

    // Instruction payload register; only written on a load so it holds
    // steady through stalls.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            opcode_reg  <= 8'h00;
            operand_reg <= 16'h0000;
            len_reg     <= 2'd0;
            ipc_reg     <= '0;
            illegal_reg <= 1'b0;
        end else if (load_en) begin
            opcode_reg  <= dec_opcode;
            operand_reg <= dec_operand;
            len_reg     <= dec_len;
            ipc_reg     <= pc_reg;
            illegal_reg <= dec_illegal;
        end
    end

    assign mem_addr_o      = pc_reg;
    assign instr_valid_o   = valid_reg;
    assign instr_opcode_o  = opcode_reg;
    assign instr_operand_o = operand_reg;
    assign instr_len_o     = len_reg;
    assign instr_pc_o      = ipc_reg;
    assign illegal_o       = illegal_reg;

endmodule
